// File: rtl/lsu_align_seq_pkg.sv
// lsu_align_seq_pkg: data_mem op codes, sequencer states and per-op access size helpers
package lsu_align_seq_pkg;
  localparam logic [2:0] MEM_LB  = 3'd0;
  localparam logic [2:0] MEM_LH  = 3'd1;
  localparam logic [2:0] MEM_LW  = 3'd2;
  localparam logic [2:0] MEM_LBU = 3'd4;
  localparam logic [2:0] MEM_LHU = 3'd5;
  localparam logic [2:0] MEM_SB  = 3'd0;
  localparam logic [2:0] MEM_SH  = 3'd1;
  localparam logic [2:0] MEM_SW  = 3'd2;
  typedef enum logic [2:0] {IDLE, LOAD_LO, LOAD_HI, STORE_B, RESP} lsu_state_e;
  function automatic logic [2:0] op_size(input logic [2:0] op);
    return op[1:0] == 2'd0 ? 3'd1 : op[1:0] == 2'd1 ? 3'd2 : 3'd4;
  endfunction
  function automatic logic op_known(input logic we, input logic [2:0] op);
    return we ? op < 3'd3 : (op != 3'd3 && op < 3'd6);
  endfunction
endpackage

// File: rtl/lsu_align_seq_if.sv
// lsu_align_seq_if: pipeline request/response and data_mem port bundle
interface lsu_align_seq_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [2:0]            req_mem_op;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  mem_wr_en;
  logic [2:0]            mem_op;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  modport master (
    output req_valid, req_we, req_mem_op, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, mem_wr_en, mem_op, mem_addr, mem_wdata
  );
  modport slave (
    input  req_valid, req_we, req_mem_op, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, mem_wr_en, mem_op, mem_addr, mem_wdata
  );
endinterface

// File: rtl/lsu_align_seq_load_extract.sv
// lsu_align_seq_load_extract: picks the addressed bytes out of {hi,lo} and extends them
module lsu_align_seq_load_extract
  import lsu_align_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] hi,
  input  logic [DATA_WIDTH-1:0] lo,
  input  logic [1:0]            off,
  input  logic [2:0]            op,
  output logic [DATA_WIDTH-1:0] data
);
  logic [DATA_WIDTH-1:0] w;
  always_comb begin
    w = DATA_WIDTH'({hi, lo} >> {off, 3'b000});
    data = op == MEM_LB  ? {{(DATA_WIDTH-8){w[7]}}, w[7:0]} :
           op == MEM_LBU ? DATA_WIDTH'(w[7:0]) :
           op == MEM_LH  ? {{(DATA_WIDTH-16){w[15]}}, w[15:0]} :
           op == MEM_LHU ? DATA_WIDTH'(w[15:0]) :
           op == MEM_LW  ? w : '0;
  end
endmodule

// File: rtl/lsu_align_seq.sv
// lsu_align_seq: turns misaligned loads/stores into aligned data_mem beats
module lsu_align_seq
  import lsu_align_seq_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input logic            clk,
  input logic            rst_n,
  lsu_align_seq_if.slave bus
);
  lsu_state_e            state;
  logic                  req_ready, rsp_valid, mem_wr_en;
  logic [DATA_WIDTH-1:0] rsp_rdata, mem_wdata, wdata_q, lo_q, ext, ex_hi, ex_lo;
  logic [ADDR_WIDTH-1:0] mem_addr, lo_addr;
  logic [2:0]            mem_op, op_q, sz;
  logic [1:0]            off, off_q, beat_q, last_q, nxt;
  logic [3:0]            end_b;
  logic                  known, store, aligned, known_q, split_q, span_q;
  always_comb begin
    off = bus.req_addr[1:0];
    sz = op_size(bus.req_mem_op);
    known = op_known(bus.req_we, bus.req_mem_op);
    store = bus.req_we && known;
    aligned = !known || sz == 3'd1 || (sz == 3'd2 && !off[0]) || off == 2'd0;
    end_b = {2'b00, off} + {1'b0, sz};
    lo_addr = {bus.req_addr[ADDR_WIDTH-1:2], 2'b00};
    nxt = beat_q + 2'd1;
    ex_hi = state == LOAD_HI ? bus.mem_rdata : '0;
    ex_lo = state == LOAD_HI ? lo_q : bus.mem_rdata;
  end
  lsu_align_seq_load_extract #(.DATA_WIDTH(DATA_WIDTH)) u_extract (
    .hi(ex_hi),
    .lo(ex_lo),
    .off(off_q),
    .op(op_q),
    .data(ext)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      mem_wr_en <= 1'b0;
      mem_op <= 3'd0;
      mem_addr <= '0;
      mem_wdata <= '0;
      wdata_q <= '0;
      lo_q <= '0;
      op_q <= 3'd0;
      off_q <= 2'd0;
      beat_q <= 2'd0;
      last_q <= 2'd0;
      known_q <= 1'b0;
      split_q <= 1'b0;
      span_q <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: if (bus.req_valid && req_ready) begin
          op_q <= bus.req_mem_op;
          off_q <= off;
          wdata_q <= bus.req_wdata;
          beat_q <= 2'd0;
          last_q <= aligned ? 2'd0 : sz == 3'd2 ? 2'd1 : 2'd3;
          known_q <= known;
          split_q <= !aligned;
          span_q <= end_b > 4'd4;
          req_ready <= 1'b0;
          mem_wr_en <= store;
          mem_op <= aligned ? bus.req_mem_op : store ? MEM_SB : MEM_LW;
          mem_addr <= aligned || store ? bus.req_addr : lo_addr;
          mem_wdata <= store && !aligned ? DATA_WIDTH'(bus.req_wdata[7:0]) : bus.req_wdata;
          state <= store ? STORE_B : LOAD_LO;
        end
        LOAD_LO: begin
          lo_q <= bus.mem_rdata;
          if (split_q && span_q) begin
            state <= LOAD_HI;
            mem_addr <= mem_addr + ADDR_WIDTH'(4);
          end else begin
            state <= RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= !known_q ? '0 : split_q ? ext : bus.mem_rdata;
            mem_op <= MEM_LW;
          end
        end
        LOAD_HI: begin
          state <= RESP;
          rsp_valid <= 1'b1;
          rsp_rdata <= ext;
          mem_op <= MEM_LW;
        end
        STORE_B: begin
          if (beat_q == last_q) begin
            state <= RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= '0;
            mem_wr_en <= 1'b0;
            mem_op <= MEM_LW;
          end else begin
            beat_q <= nxt;
            mem_addr <= mem_addr + ADDR_WIDTH'(1);
            mem_wdata <= DATA_WIDTH'(wdata_q[{nxt, 3'b000} +: 8]);
          end
        end
        default: begin
          state <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end
  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_rdata = rsp_rdata;
  assign bus.mem_wr_en = mem_wr_en;
  assign bus.mem_op = mem_op;
  assign bus.mem_addr = mem_addr;
  assign bus.mem_wdata = mem_wdata;
endmodule

// File: tb/tb_lsu_align_seq.sv
// tb_lsu_align_seq: directed vectors against a byte-array data_mem model
module tb_lsu_align_seq;
  import lsu_align_seq_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  lsu_align_seq_if bus ();
  lsu_align_seq dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  logic [7:0] mem [256];
  logic [7:0] b0, b1, b2, b3, wa;
  int pass_cnt = 0;
  int total = 0;
  logic [31:0] ba [10];
  logic [31:0] bd [10];
  logic [2:0] bo [10];
  logic bw [10];
  always_comb begin
    b0 = mem[bus.mem_addr[7:0]];
    b1 = mem[bus.mem_addr[7:0] + 8'd1];
    b2 = mem[bus.mem_addr[7:0] + 8'd2];
    b3 = mem[bus.mem_addr[7:0] + 8'd3];
    bus.mem_rdata = bus.mem_op == MEM_LB  ? {{24{b0[7]}}, b0} :
                    bus.mem_op == MEM_LBU ? {24'd0, b0} :
                    bus.mem_op == MEM_LH  ? {{16{b1[7]}}, b1, b0} :
                    bus.mem_op == MEM_LHU ? {16'd0, b1, b0} : {b3, b2, b1, b0};
  end
  always @(posedge clk) if (bus.mem_wr_en) begin
    wa = bus.mem_addr[7:0];
    mem[wa] = bus.mem_wdata[7:0];
    if (bus.mem_op != MEM_SB) mem[wa + 8'd1] = bus.mem_wdata[15:8];
    if (bus.mem_op == MEM_SW) begin
      mem[wa + 8'd2] = bus.mem_wdata[23:16];
      mem[wa + 8'd3] = bus.mem_wdata[31:24];
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  task automatic xact(input logic we, input logic [2:0] op, input logic [31:0] a, input logic [31:0] d,
                      output int lat, output logic [31:0] rd);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we = we;
    bus.req_mem_op = op;
    bus.req_addr = a;
    bus.req_wdata = d;
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.rsp_valid && lat < 10) begin
      ba[lat-1] = bus.mem_addr;
      bd[lat-1] = bus.mem_wdata;
      bo[lat-1] = bus.mem_op;
      bw[lat-1] = bus.mem_wr_en;
      @(negedge clk);
      lat++;
    end
    rd = bus.rsp_rdata;
  endtask
  function automatic logic [31:0] word_at(input logic [7:0] a);
    return {mem[a + 8'd3], mem[a + 8'd2], mem[a + 8'd1], mem[a]};
  endfunction
  typedef struct {
    logic        we;
    logic [2:0]  op;
    logic [31:0] addr, wdata, exp_rd;
    int          lat;
    logic [31:0] a0, a1;
    logic [2:0]  op0;
    logic [31:0] d0;
    logic        w0;
  } vec_t;
  vec_t vt[$];
  int lat, n;
  logic [31:0] rd;
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    {mem[8'h13], mem[8'h12], mem[8'h11], mem[8'h10]} = 32'h44332211;
    {mem[8'h17], mem[8'h16], mem[8'h15], mem[8'h14]} = 32'hF8776655;
    {mem[8'hFF], mem[8'hFE], mem[8'hFD], mem[8'hFC]} = 32'hD4C3B2A1;
    {mem[8'h03], mem[8'h02], mem[8'h01], mem[8'h00]} = 32'h1807F6E5;
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_mem_op = 3'd0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    //            we op       addr          wdata         exp_rd        lat a0            a1            op0      d0     w0
    vt.push_back(vec_t'{0, MEM_LW,  32'h10,       0,            32'h44332211, 2, 32'h10,       0,            MEM_LW,  0,     0});
    vt.push_back(vec_t'{0, MEM_LW,  32'h12,       0,            32'h66554433, 3, 32'h10,       32'h14,       MEM_LW,  0,     0});
    vt.push_back(vec_t'{0, MEM_LH,  32'h13,       0,            32'h00005544, 3, 32'h10,       32'h14,       MEM_LW,  0,     0});
    vt.push_back(vec_t'{0, MEM_LH,  32'h16,       0,            32'hFFFFF877, 2, 32'h16,       0,            MEM_LH,  0,     0});
    vt.push_back(vec_t'{0, MEM_LHU, 32'h16,       0,            32'h0000F877, 2, 32'h16,       0,            MEM_LHU, 0,     0});
    vt.push_back(vec_t'{0, MEM_LH,  32'h11,       0,            32'h00003322, 2, 32'h10,       0,            MEM_LW,  0,     0});
    vt.push_back(vec_t'{0, MEM_LB,  32'h17,       0,            32'hFFFFFFF8, 2, 32'h17,       0,            MEM_LB,  0,     0});
    vt.push_back(vec_t'{0, MEM_LBU, 32'h17,       0,            32'h000000F8, 2, 32'h17,       0,            MEM_LBU, 0,     0});
    vt.push_back(vec_t'{0, MEM_LW,  32'h11,       0,            32'h55443322, 3, 32'h10,       32'h14,       MEM_LW,  0,     0});
    vt.push_back(vec_t'{0, MEM_LH,  32'hFF,       0,            32'hFFFFE5D4, 3, 32'hFC,       32'h100,      MEM_LW,  0,     0});
    vt.push_back(vec_t'{0, MEM_LW,  32'hFFFFFFFE, 0,            32'hF6E5D4C3, 3, 32'hFFFFFFFC, 32'h0,        MEM_LW,  0,     0});
    vt.push_back(vec_t'{0, 3'd3,    32'h10,       0,            32'h0,        2, 32'h10,       0,            3'd3,    0,     0});
    vt.push_back(vec_t'{1, MEM_SW,  32'h18,       32'h01020304, 32'h0,        2, 32'h18,       0,            MEM_SW,  32'h01020304, 1});
    vt.push_back(vec_t'{0, MEM_LW,  32'h18,       0,            32'h01020304, 2, 32'h18,       0,            MEM_LW,  0,     0});
    vt.push_back(vec_t'{1, MEM_SH,  32'h1B,       32'h1234BEEF, 32'h0,        3, 32'h1B,       32'h1C,       MEM_SB,  32'hEF, 1});
    vt.push_back(vec_t'{0, MEM_LW,  32'h18,       0,            32'hEF020304, 2, 32'h18,       0,            MEM_LW,  0,     0});
    vt.push_back(vec_t'{0, MEM_LW,  32'h1C,       0,            32'h000000BE, 2, 32'h1C,       0,            MEM_LW,  0,     0});
    vt.push_back(vec_t'{1, MEM_SW,  32'h11,       32'hAABBCCDD, 32'h0,        5, 32'h11,       32'h12,       MEM_SB,  32'hDD, 1});
    vt.push_back(vec_t'{0, MEM_LW,  32'h10,       0,            32'hBBCCDD11, 2, 32'h10,       0,            MEM_LW,  0,     0});
    vt.push_back(vec_t'{0, MEM_LW,  32'h14,       0,            32'hF87766AA, 2, 32'h14,       0,            MEM_LW,  0,     0});
    vt.push_back(vec_t'{1, MEM_SB,  32'h1D,       32'h00000077, 32'h0,        2, 32'h1D,       0,            MEM_SB,  32'h77, 1});
    vt.push_back(vec_t'{1, 3'd4,    32'h1C,       32'hFFFFFFFF, 32'h0,        2, 32'h1C,       0,            3'd4,    32'hFFFFFFFF, 0});
    vt.push_back(vec_t'{0, MEM_LW,  32'h1C,       0,            32'h000077BE, 2, 32'h1C,       0,            MEM_LW,  0,     0});
    // reset state
    @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_rsp", {31'd0, bus.rsp_valid} | bus.rsp_rdata, 32'd0);
    chk("rst_mem_ctl", {28'd0, bus.mem_wr_en, bus.mem_op}, 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    rst_n = 1'b1;
    foreach (vt[k]) begin
      xact(vt[k].we, vt[k].op, vt[k].addr, vt[k].wdata, lat, rd);
      chk($sformatf("v%0d_rdata", k), rd, vt[k].exp_rd);
      chk($sformatf("v%0d_latency", k), 32'(lat), 32'(vt[k].lat));
      chk($sformatf("v%0d_beat0_addr", k), ba[0], vt[k].a0);
      chk($sformatf("v%0d_beat0_op", k), 32'(bo[0]), 32'(vt[k].op0));
      chk($sformatf("v%0d_beat0_wr_en", k), 32'(bw[0]), 32'(vt[k].w0));
      if (vt[k].lat > 2) chk($sformatf("v%0d_beat1_addr", k), ba[1], vt[k].a1);
      if (vt[k].we) chk($sformatf("v%0d_beat0_wdata", k), bd[0], vt[k].d0);
    end
    // every beat of a 4-beat misaligned store
    xact(1'b1, MEM_SW, 32'h21, 32'hAABBCCDD, lat, rd);
    chk("sw4_latency", 32'(lat), 32'd5);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("sw4_beat%0d_addr", i), ba[i], 32'h21 + 32'(i));
      chk($sformatf("sw4_beat%0d_data", i), bd[i], 32'(8'hDD - 8'(i * 8'h11)));
      chk($sformatf("sw4_beat%0d_ctl", i), {28'd0, bw[i], bo[i]}, {28'd0, 1'b1, MEM_SB});
    end
    chk("sw4_mem_word", word_at(8'h21), 32'hAABBCCDD);
    chk("sw4_mem_edges", {24'd0, mem[8'h20] | mem[8'h25]}, 32'd0);
    // reset during beat 2 of a 4-beat store
    {mem[8'h13], mem[8'h12], mem[8'h11], mem[8'h10]} = 32'h44332211;
    {mem[8'h17], mem[8'h16], mem[8'h15], mem[8'h14]} = 32'hF8776655;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we = 1'b1;
    bus.req_mem_op = MEM_SW;
    bus.req_addr = 32'h11;
    bus.req_wdata = 32'hAABBCCDD;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("rstmid_beat2", {bus.mem_addr[30:0], bus.mem_wr_en}, {31'h12, 1'b1});
    rst_n = 1'b0;
    @(negedge clk);
    chk("rstmid_state", 32'(dut.state), 32'(IDLE));
    chk("rstmid_ready", 32'(bus.req_ready), 32'd1);
    chk("rstmid_quiet", {30'd0, bus.mem_wr_en, bus.rsp_valid}, 32'd0);
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n += int'(bus.rsp_valid) + int'(bus.mem_wr_en);
    end
    chk("rstmid_no_activity", 32'(n), 32'd0);
    chk("rstmid_word10", word_at(8'h10), 32'h44CCDD11);
    chk("rstmid_word14", word_at(8'h14), 32'hF8776655);
    // req_valid held high while busy must be taken once
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we = 1'b0;
    bus.req_mem_op = MEM_LW;
    bus.req_addr = 32'h10;
    @(negedge clk);
    chk("busy_ready_low", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    chk("busy_rsp", {bus.rsp_valid, bus.rsp_rdata[30:0]}, {1'b1, 31'h44CCDD11});
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("busy_ready_back", {30'd0, bus.req_ready, bus.rsp_valid}, 32'd2);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n += int'(bus.rsp_valid);
    end
    chk("busy_single_accept", 32'(n), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
